// File: rtl/tas_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// tas_pkg : header constants, packet length and receiver state type. Rev 1.0
//------------------------------------------------------------------------------
package tas_pkg;

   localparam logic [7:0] HDR_A5      = 8'hA5;
   localparam logic [7:0] HDR_C3      = 8'hC3;
   localparam int         PKT_LEN     = 5;
   localparam logic [2:0] PKT_LAST    = 3'(PKT_LEN - 1);
   localparam logic [3:0] BYTE_BITS   = 4'd8;
   localparam logic [3:0] BIT_CNT_MAX = 4'd9;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      IDLE  = 2'd1,
      SHIFT = 2'd2
   } rx_state_t;

   function automatic logic is_header(input logic [7:0] b);
      return (b == HDR_A5) || (b == HDR_C3);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ser_rx_50_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// ser_rx_50_if : serial input and assembled-byte outputs of ser_rx_50. Rev 1.0
//------------------------------------------------------------------------------
interface ser_rx_50_if;

   logic       serial_data;
   logic       data_ena;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       a5c3;
   logic       frame_err;
   logic [2:0] pkt_idx;

   modport master (
      output serial_data, data_ena,
      input  byte_out, byte_valid, a5c3, frame_err, pkt_idx
   );

   modport slave (
      input  serial_data, data_ena,
      output byte_out, byte_valid, a5c3, frame_err, pkt_idx
   );

endinterface
`default_nettype wire

// File: rtl/shift8.sv
`default_nettype none
//------------------------------------------------------------------------------
// shift8 : MSB-first shift register with saturating bit counter. Rev 1.0
//------------------------------------------------------------------------------
module shift8
   import tas_pkg::*;
(
   input  logic       clk_50,
   input  logic       reset_n,
   input  logic       load,
   input  logic       shift,
   input  logic       clear,
   input  logic       serial_data,
   output logic [7:0] shreg,
   output logic [3:0] bit_cnt
);

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         shreg   <= 8'h00;
         bit_cnt <= 4'd0;
      end else if (load) begin
         shreg   <= {shreg[6:0], serial_data};
         bit_cnt <= 4'd1;
      end else if (shift) begin
         shreg <= {shreg[6:0], serial_data};
         // Saturation keeps any overrun distinguishable from a clean byte.
         if (bit_cnt != BIT_CNT_MAX) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else if (clear) begin
         bit_cnt <= 4'd0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ser_rx_50.sv
`default_nettype none
//------------------------------------------------------------------------------
// ser_rx_50 : gated serial-to-byte receiver with packet position tracking. Rev 1.0
//------------------------------------------------------------------------------
module ser_rx_50
   import tas_pkg::*;
(
   input  logic        clk_50,
   input  logic        reset_n,
   ser_rx_50_if.slave  rx
);

   rx_state_t  state;
   rx_state_t  state_nx;
   logic       load;
   logic       shift;
   logic       byte_done;
   logic       byte_bad;
   logic [7:0] shreg;
   logic [3:0] bit_cnt;

   shift8 u_shift8 (
      .clk_50      (clk_50),
      .reset_n     (reset_n),
      .load        (load),
      .shift       (shift),
      .clear       (!rx.data_ena),
      .serial_data (rx.serial_data),
      .shreg       (shreg),
      .bit_cnt     (bit_cnt)
   );

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= SYNC;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      load      = 1'b0;
      shift     = 1'b0;
      byte_done = 1'b0;
      byte_bad  = 1'b0;
      case (state)
         SYNC: begin
            if (!rx.data_ena) begin
               state_nx = IDLE;
            end
         end
         IDLE: begin
            if (rx.data_ena) begin
               state_nx = SHIFT;
               load     = 1'b1;
            end
         end
         SHIFT: begin
            if (rx.data_ena) begin
               shift = 1'b1;
            end else begin
               state_nx = IDLE;
               if (bit_cnt == BYTE_BITS) begin
                  byte_done = 1'b1;
               end else begin
                  byte_bad = 1'b1;
               end
            end
         end
         default: state_nx = SYNC;
      endcase
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         rx.byte_out   <= 8'h00;
         rx.byte_valid <= 1'b0;
         rx.frame_err  <= 1'b0;
         rx.pkt_idx    <= 3'd0;
      end else begin
         rx.byte_valid <= byte_done;
         rx.frame_err  <= byte_bad;
         if (byte_done) begin
            rx.byte_out <= shreg;
            rx.pkt_idx  <= (rx.pkt_idx == PKT_LAST) ? 3'd0 : rx.pkt_idx + 3'd1;
         end else if (byte_bad) begin
            rx.pkt_idx <= 3'd0;
         end
      end
   end

   // Decoded from registers so it is already valid in the falling-edge cycle.
   assign rx.a5c3 = is_header(shreg) && (bit_cnt == BYTE_BITS) && (rx.pkt_idx == 3'd0);

endmodule
`default_nettype wire
